// File: rtl/ring_counter_gen.sv
// ---------------------------------------------------------------------------
// ring_counter_gen
//
// Self-correcting ring / Johnson sequencer for phase selection and scan
// strobes. The counter rotates a one-hot pattern (ring) or a twisted-ring
// thermometer pattern (Johnson). Shift direction, enable and parallel load
// are selectable at runtime. Illegal states are flagged and, optionally,
// replaced by the base pattern.
//
// Parameters
//   WIDTH        counter width in bits (2..32)
//   SELF_CORRECT 1: an illegal state is replaced by the base pattern on the
//                   next enabled cycle
//                0: an illegal state shifts unchanged and is only flagged
//
// Ports
//   clk       clock, rising edge
//   rst       synchronous, active-high reset
//   en        advance one step this cycle
//   mode      0 = ring (one-hot rotate), 1 = Johnson (twisted ring)
//   dir       0 = shift toward MSB, 1 = shift toward LSB
//   load      parallel load of load_val this cycle
//   load_val  value to load
//   q         registered counter state
//   valid     q is legal for the registered mode (decoded from registers)
//   wrap      registered one-cycle pulse: an enabled legal shift returned q
//             to the base pattern
//   err       sticky illegal-state flag, cleared only by rst
// ---------------------------------------------------------------------------
module ring_counter_gen #(
    parameter int WIDTH        = 4,
    parameter bit SELF_CORRECT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             wrap,
    output logic             err
);

    // Base pattern: ring starts with bit 0 set, Johnson starts all zeros.
    function automatic logic [WIDTH-1:0] base_pat(input logic m);
        logic [WIDTH-1:0] b;
        b = '0;
        if (!m) b[0] = 1'b1;
        return b;
    endfunction

    // Ring: exactly one bit set. Johnson: at most one transition between
    // adjacent bits, which admits exactly the 2*WIDTH thermometer states.
    function automatic logic is_legal(input logic [WIDTH-1:0] v, input logic m);
        int cnt;
        cnt = 0;
        if (!m) begin
            for (int i = 0; i < WIDTH; i++)
                if (v[i]) cnt = cnt + 1;
            return (cnt == 1);
        end
        for (int i = 0; i < WIDTH - 1; i++)
            if (v[i] != v[i+1]) cnt = cnt + 1;
        return (cnt <= 1);
    endfunction

    // One step of the sequence; Johnson feeds back the inverted outgoing bit.
    function automatic logic [WIDTH-1:0] shift_pat(input logic [WIDTH-1:0] v,
                                                   input logic m,
                                                   input logic d);
        logic [WIDTH-1:0] s;
        if (!d) s = {v[WIDTH-2:0], (m ? ~v[WIDTH-1] : v[WIDTH-1])};
        else    s = {(m ? ~v[0] : v[0]), v[WIDTH-1:1]};
        return s;
    endfunction

    logic [WIDTH-1:0] r_q;
    logic             r_mode;
    logic             r_wrap;
    logic             r_err;

    logic [WIDTH-1:0] w_q_nxt;
    logic             w_mode_nxt;
    logic             w_wrap_nxt;
    logic             w_err_nxt;
    logic             w_legal;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_base_cur;

    assign w_legal    = is_legal(r_q, r_mode);
    assign w_shift    = shift_pat(r_q, r_mode, dir);
    assign w_base_cur = base_pat(r_mode);

    // Next-state decode. Priority below reset: mode change > load > en > hold.
    always_comb begin
        w_q_nxt    = r_q;
        w_mode_nxt = r_mode;
        w_wrap_nxt = 1'b0;
        w_err_nxt  = r_err;
        if (mode != r_mode) begin
            // Restart the sequence cleanly in the new mode; load/en ignored.
            w_q_nxt    = base_pat(mode);
            w_mode_nxt = mode;
        end else if (load) begin
            // The loaded value itself is judged on a later enabled cycle;
            // only the state being overwritten is checked here.
            w_q_nxt = load_val;
            if (!w_legal) w_err_nxt = 1'b1;
        end else if (en) begin
            if (!w_legal) begin
                w_err_nxt = 1'b1;
                w_q_nxt   = SELF_CORRECT ? w_base_cur : w_shift;
            end else begin
                w_q_nxt    = w_shift;
                w_wrap_nxt = (w_shift == w_base_cur);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= base_pat(mode);
            r_mode <= mode;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_mode <= w_mode_nxt;
            r_wrap <= w_wrap_nxt;
            r_err  <= w_err_nxt;
        end
    end

    assign q     = r_q;
    assign valid = w_legal;
    assign wrap  = r_wrap;
    assign err   = r_err;

endmodule

// File: tb/tb_ring_counter_gen.sv
module tb_ring_counter_gen;

    logic       clk = 1'b0;
    logic       rst, en, mode, dir, load;
    logic [3:0] load_val;
    logic [3:0] q, q_nc;
    logic       valid, wrap, err;
    logic       valid_nc, wrap_nc, err_nc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ring_counter_gen #(.WIDTH(4), .SELF_CORRECT(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
        .load_val(load_val), .q(q), .valid(valid), .wrap(wrap), .err(err)
    );

    ring_counter_gen #(.WIDTH(4), .SELF_CORRECT(1'b0)) dut_nc (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
        .load_val(load_val), .q(q_nc), .valid(valid_nc), .wrap(wrap_nc), .err(err_nc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic m);
        rst = 1'b1; en = 1'b0; load = 1'b0; dir = 1'b0; mode = m; load_val = 4'b0000;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; load = 1'b0; dir = 1'b0; mode = 1'b0; load_val = 4'b0000;
        step();
        rst = 1'b0; en = 1'b0;
        n_tests++;
        if (q !== 4'b0001 || wrap !== 1'b0 || err !== 1'b0 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset q=%b wrap=%b err=%b valid=%b exp q=0001 wrap=0 err=0 valid=1", q, wrap, err, valid);
        end
        n_tests++;
        if (q_nc !== 4'b0001 || wrap_nc !== 1'b0 || err_nc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_nc q=%b wrap=%b err=%b exp q=0001 wrap=0 err=0", q_nc, wrap_nc, err_nc);
        end
    endtask

    task automatic test_ring_fwd();
        logic [3:0] eq [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic       ew [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset(1'b0);
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests++;
            if (q !== eq[i] || wrap !== ew[i] || valid !== 1'b1 || q_nc !== eq[i]) begin
                n_fail++;
                $display("FAIL ring_fwd step %0d q=%b q_nc=%b wrap=%b valid=%b exp q=%b wrap=%b valid=1",
                         i, q, q_nc, wrap, valid, eq[i], ew[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_johnson();
        logic [3:0] eq [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                               4'b1110, 4'b1100, 4'b1000, 4'b0000};
        do_reset(1'b1);
        n_tests++;
        if (q !== 4'b0000 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL johnson_base q=%b valid=%b exp q=0000 valid=1", q, valid);
        end
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_tests++;
            if (q !== eq[i] || wrap !== (i == 7) || valid !== 1'b1) begin
                n_fail++;
                $display("FAIL johnson step %0d q=%b wrap=%b valid=%b exp q=%b wrap=%b valid=1",
                         i, q, wrap, valid, eq[i], (i == 7));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_ring_rev_hold();
        logic [3:0] eq [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        do_reset(1'b0);
        dir = 1'b1; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (q !== eq[i] || wrap !== (i == 3)) begin
                n_fail++;
                $display("FAIL ring_rev step %0d q=%b wrap=%b exp q=%b wrap=%b", i, q, wrap, eq[i], (i == 3));
            end
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (q !== 4'b0001 || wrap !== 1'b0) begin
                n_fail++;
                $display("FAIL hold step %0d q=%b wrap=%b exp q=0001 wrap=0", i, q, wrap);
            end
        end
        dir = 1'b0;
    endtask

    task automatic test_dir_change();
        do_reset(1'b0);
        en = 1'b1; dir = 1'b0;
        step();
        dir = 1'b1;
        step();
        n_tests++;
        if (q !== 4'b0001 || wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL dir_change q=%b wrap=%b exp q=0001 wrap=1", q, wrap);
        end
        step();
        n_tests++;
        if (q !== 4'b1000 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL dir_change2 q=%b wrap=%b exp q=1000 wrap=0", q, wrap);
        end
        en = 1'b0; dir = 1'b0;
    endtask

    task automatic test_illegal_load();
        do_reset(1'b0);
        load = 1'b1; load_val = 4'b0110;
        step();
        load = 1'b0;
        n_tests++;
        if (q !== 4'b0110 || valid !== 1'b0 || err !== 1'b0 || q_nc !== 4'b0110 || err_nc !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_load q=%b valid=%b err=%b q_nc=%b err_nc=%b exp q=0110 valid=0 err=0",
                     q, valid, err, q_nc, err_nc);
        end
        en = 1'b1;
        step();
        n_tests++;
        if (q !== 4'b0001 || err !== 1'b1 || wrap !== 1'b0 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL self_correct q=%b err=%b wrap=%b valid=%b exp q=0001 err=1 wrap=0 valid=1",
                     q, err, wrap, valid);
        end
        n_tests++;
        if (q_nc !== 4'b1100 || err_nc !== 1'b1 || wrap_nc !== 1'b0) begin
            n_fail++;
            $display("FAIL no_correct q=%b err=%b wrap=%b exp q=1100 err=1 wrap=0", q_nc, err_nc, wrap_nc);
        end
        en = 1'b0;
        step();
        step();
        en = 1'b1;
        step();
        n_tests++;
        if (q !== 4'b0010 || err !== 1'b1 || q_nc !== 4'b1001 || err_nc !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky q=%b err=%b q_nc=%b err_nc=%b exp q=0010 err=1 q_nc=1001 err_nc=1",
                     q, err, q_nc, err_nc);
        end
        en = 1'b0;
    endtask

    task automatic test_mode_change();
        logic [3:0] eq [2] = '{4'b0001, 4'b0011};
        do_reset(1'b0);
        en = 1'b1;
        step();
        step();
        n_tests++;
        if (q !== 4'b0100) begin
            n_fail++;
            $display("FAIL mode_pre q=%b exp 0100", q);
        end
        mode = 1'b1; load = 1'b1; load_val = 4'b1010;
        step();
        load = 1'b0;
        n_tests++;
        if (q !== 4'b0000 || wrap !== 1'b0 || valid !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL mode_change q=%b wrap=%b valid=%b err=%b exp q=0000 wrap=0 valid=1 err=0",
                     q, wrap, valid, err);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if (q !== eq[i] || wrap !== 1'b0) begin
                n_fail++;
                $display("FAIL mode_follow step %0d q=%b wrap=%b exp q=%b wrap=0", i, q, wrap, eq[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_reset_priority();
        do_reset(1'b1);
        load = 1'b1; load_val = 4'b1010;
        step();
        load = 1'b0; en = 1'b1;
        step();
        n_tests++;
        if (q !== 4'b0000 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL johnson_correct q=%b err=%b exp q=0000 err=1", q, err);
        end
        step(); step(); step();
        n_tests++;
        if (q !== 4'b0111) begin
            n_fail++;
            $display("FAIL johnson_pre q=%b exp 0111", q);
        end
        rst = 1'b1; load = 1'b1; load_val = 4'b1010; en = 1'b1;
        step();
        rst = 1'b0; load = 1'b0;
        n_tests++;
        if (q !== 4'b0000 || err !== 1'b0 || wrap !== 1'b0 || err_nc !== 1'b0 || q_nc !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_prio q=%b err=%b wrap=%b q_nc=%b err_nc=%b exp q=0000 err=0 wrap=0",
                     q, err, wrap, q_nc, err_nc);
        end
        step();
        step();
        n_tests++;
        if (q !== 4'b0011 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_resume q=%b err=%b exp q=0011 err=0", q, err);
        end
        en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = 4'b0000;
        #2;
        test_reset();
        test_ring_fwd();
        test_johnson();
        test_ring_rev_hold();
        test_dir_change();
        test_illegal_load();
        test_mode_change();
        test_reset_priority();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
